// File: rtl/sha1_msg_padder.sv
// SHA-1 message front end: packs a big-endian word stream into 512-bit blocks, pads them and streams them to sha1_core.
// Optional unpadded pass-through mode is enabled by defining SHA1_PAD_RAW_EN.
module sha1_msg_padder #(
    parameter int LEN_W = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        msg_vld,
    input  logic [31:0] msg_data,
    input  logic        msg_last,
    input  logic [1:0]  msg_bytes,
`ifdef SHA1_PAD_RAW_EN
    input  logic        raw_mode,
`endif
    output logic        msg_rdy,
    input  logic        core_busy,
    input  logic        core_dout_vld,
    output logic        blk_vld,
    output logic [31:0] blk_data,
    output logic        blk_cont,
    output logic        msg_done
);

    typedef enum logic [2:0] {IDLE, FILL, PAD, SEND, WAIT} state_t;

    state_t state_q, state_d;

    logic [31:0]      blk_buf [16];
    logic [3:0]       idx_q;
    logic [3:0]       send_cnt_q;
    logic [LEN_W-1:0] len_q;
    logic [3:0]       last_j_q;
    logic [2:0]       last_b_q;
    logic             fin_q;
    logic             ext_q;
    logic             ext_mark_q;
    logic             cont_q;
    logic             live_q;

    logic             accept;
    logic [3:0]       wr_idx;
    logic [2:0]       word_bytes;
    logic [LEN_W-1:0] len_add;
    logic [63:0]      len64;
    logic [4:0]       e_pos;
    logic [31:0]      marked_word;
    logic             raw_eff;

`ifdef SHA1_PAD_RAW_EN
    logic raw_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_q <= 1'b0;
        end else if (accept && state_q == IDLE) begin
            raw_q <= raw_mode;
        end
    end

    assign raw_eff = (state_q == IDLE) ? raw_mode : raw_q;
`else
    assign raw_eff = 1'b0;
`endif

    assign accept     = msg_vld && msg_rdy;
    assign wr_idx     = (state_q == IDLE) ? 4'd0 : idx_q;
    assign word_bytes = (msg_last && msg_bytes != 2'd0) ? {1'b0, msg_bytes} : 3'd4;
    // A full final word pushes the 0x80 marker into the following word slot
    assign e_pos      = {1'b0, last_j_q} + ((last_b_q == 3'd4) ? 5'd1 : 5'd0);
    assign blk_data   = blk_vld ? blk_buf[send_cnt_q] : 32'h0;
    assign blk_cont   = cont_q;

    always_comb begin
        len_add      = '0;
        len_add[5:0] = {word_bytes, 3'b000};
        len64              = '0;
        len64[LEN_W-1:0]   = len_q;
    end

    always_comb begin
        marked_word = blk_buf[last_j_q];
        case (last_b_q)
            3'd1:    marked_word = {blk_buf[last_j_q][31:24], 24'h80_0000};
            3'd2:    marked_word = {blk_buf[last_j_q][31:16], 16'h8000};
            3'd3:    marked_word = {blk_buf[last_j_q][31:8], 8'h80};
            default: marked_word = blk_buf[last_j_q];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        msg_rdy  = 1'b0;
        blk_vld  = 1'b0;
        msg_done = 1'b0;
        case (state_q)
            IDLE, FILL: begin
                msg_rdy = live_q;
                if (msg_vld && live_q) begin
                    if (msg_last) begin
                        if (!raw_eff) begin
                            state_d = PAD;
                        end else if (wr_idx == 4'd15) begin
                            state_d = SEND;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (wr_idx == 4'd15) begin
                        state_d = SEND;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            PAD: state_d = SEND;
            SEND: begin
                // Once a burst starts it runs to completion regardless of core_busy
                blk_vld = (send_cnt_q != 4'd0) || !core_busy;
                if (blk_vld && send_cnt_q == 4'd15) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (core_dout_vld) begin
                    if (ext_q) begin
                        state_d = SEND;
                    end else if (fin_q) begin
                        msg_done = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 16; k++) begin
                blk_buf[k] <= '0;
            end
            idx_q      <= '0;
            send_cnt_q <= '0;
            len_q      <= '0;
            last_j_q   <= '0;
            last_b_q   <= '0;
            fin_q      <= 1'b0;
            ext_q      <= 1'b0;
            ext_mark_q <= 1'b0;
            cont_q     <= 1'b0;
            live_q     <= 1'b0;
        end else begin
            live_q <= 1'b1;
            if (accept) begin
                blk_buf[wr_idx] <= msg_data;
                idx_q           <= wr_idx + 4'd1;
                len_q           <= ((state_q == IDLE) ? '0 : len_q) + len_add;
                fin_q           <= msg_last;
                if (msg_last) begin
                    last_j_q <= wr_idx;
                    last_b_q <= word_bytes;
                end
                if (state_q == IDLE) begin
                    cont_q <= 1'b0;
                end
            end
            if (state_q == PAD) begin
                for (int k = 0; k < 16; k++) begin
                    if (4'(k) == last_j_q && last_b_q != 3'd4) begin
                        blk_buf[k] <= marked_word;
                    end else if (5'(k) == e_pos) begin
                        blk_buf[k] <= 32'h8000_0000;
                    end else if (5'(k) > e_pos) begin
                        if (e_pos <= 5'd13 && k == 14) begin
                            blk_buf[k] <= len64[63:32];
                        end else if (e_pos <= 5'd13 && k == 15) begin
                            blk_buf[k] <= len64[31:0];
                        end else begin
                            blk_buf[k] <= '0;
                        end
                    end
                end
                ext_q      <= (e_pos >= 5'd14);
                ext_mark_q <= (e_pos == 5'd16);
            end
            if (blk_vld) begin
                send_cnt_q <= send_cnt_q + 4'd1;
                if (send_cnt_q == 4'd15) begin
                    cont_q <= 1'b1;
                end
            end
            // Length did not fit: the trailing block carries only the marker (maybe) and the length
            if (state_q == WAIT && core_dout_vld) begin
                idx_q <= '0;
                if (ext_q) begin
                    for (int k = 0; k < 16; k++) begin
                        blk_buf[k] <= '0;
                    end
                    if (ext_mark_q) begin
                        blk_buf[0] <= 32'h8000_0000;
                    end
                    blk_buf[14] <= len64[63:32];
                    blk_buf[15] <= len64[31:0];
                    ext_q       <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sha1_msg_padder.sv
// Randomized bench for sha1_msg_padder: a byte-level padding model fills a scoreboard that a monitor drains
// as blocks stream out, with a simple sha1_core stand-in answering each block.
module tb_sha1_msg_padder;

    typedef byte unsigned bytes_t[$];
    typedef struct {
        logic [31:0] data;
        logic        cont;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        msg_vld;
    logic [31:0] msg_data;
    logic        msg_last;
    logic [1:0]  msg_bytes;
    logic        msg_rdy;
    logic        core_busy;
    logic        core_busy_m;
    logic        hold_busy;
    logic        core_dout_vld;
    logic        blk_vld;
    logic [31:0] blk_data;
    logic        blk_cont;
    logic        msg_done;
`ifdef SHA1_PAD_RAW_EN
    logic        raw_mode;
`endif

    exp_t exp_q[$];
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   done_cnt  = 0;
    int   exp_done  = 0;
    bit   sb_off    = 1'b0;

    assign core_busy = core_busy_m | hold_busy;

    sha1_msg_padder #(.LEN_W(64)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .msg_vld       (msg_vld),
        .msg_data      (msg_data),
        .msg_last      (msg_last),
        .msg_bytes     (msg_bytes),
`ifdef SHA1_PAD_RAW_EN
        .raw_mode      (raw_mode),
`endif
        .msg_rdy       (msg_rdy),
        .core_busy     (core_busy),
        .core_dout_vld (core_dout_vld),
        .blk_vld       (blk_vld),
        .blk_data      (blk_data),
        .blk_cont      (blk_cont),
        .msg_done      (msg_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic bytes_t rand_msg(input int n);
        bytes_t m;
        for (int i = 0; i < n; i++) begin
            m.push_back(8'($urandom));
        end
        return m;
    endfunction

    // Reference: standard SHA-1 byte padding, then split into 16-word blocks
    function automatic void build_expected(input bytes_t m, input bit raw);
        bytes_t          p;
        longint unsigned bits;
        exp_t            e;
        p    = m;
        bits = 64'(m.size()) * 64'd8;
        if (!raw) begin
            p.push_back(8'h80);
            while (p.size() % 64 != 56) begin
                p.push_back(8'h00);
            end
            for (int i = 7; i >= 0; i--) begin
                p.push_back(8'(bits >> (8 * i)));
            end
        end
        for (int i = 0; i < p.size() / 4; i++) begin
            e.data = {p[4*i], p[4*i+1], p[4*i+2], p[4*i+3]};
            e.cont = (i >= 16);
            exp_q.push_back(e);
        end
    endfunction

    task automatic driveMessage(input bytes_t m, output bit ok);
        int          nw;
        int          cyc;
        bit          acc;
        logic [31:0] w;
        nw = (m.size() + 3) / 4;
        ok = 1'b1;
        for (int i = 0; i < nw && ok; i++) begin
            msg_vld = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            w = $urandom;
            for (int k = 0; k < 4; k++) begin
                if (4 * i + k < m.size()) w[31-8*k -: 8] = m[4*i+k];
            end
            msg_data  = w;
            msg_last  = (i == nw - 1);
            msg_bytes = msg_last ? 2'(m.size() % 4) : 2'($urandom);
            msg_vld   = 1'b1;
            cyc = 0;
            acc = 1'b0;
            while (!acc && cyc < 500) begin
                @(negedge clk);
                acc = msg_rdy;
                @(posedge clk); #1;
                cyc++;
            end
            if (!acc) begin
                checkOutput("msg_rdy_timeout", 64'd0, 64'd1);
                ok = 1'b0;
            end
        end
        msg_vld  = 1'b0;
        msg_last = 1'b0;
    endtask

    task automatic applyStimulus(input bytes_t m, input bit raw, input bit hold);
        bit ok;
        int cyc;
        build_expected(m, raw);
        exp_done++;
        if (hold) begin
            fork
                begin
                    hold_busy = 1'b1;
                    repeat (20) @(posedge clk);
                    #1;
                    hold_busy = 1'b0;
                end
            join_none
        end
        driveMessage(m, ok);
        if (ok && !raw && !hold) begin
            @(negedge clk);
            checkOutput("pad_cycle_quiet", 64'(blk_vld), 64'd0);
            @(negedge clk);
            checkOutput("first_beat_latency", 64'(blk_vld), 64'd1);
            @(posedge clk); #1;
        end
        cyc = 0;
        while (done_cnt < exp_done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("msg_done_count", 64'(done_cnt), 64'(exp_done));
        @(posedge clk); #1;
        while (hold_busy) begin
            @(posedge clk); #1;
        end
    endtask

    // Stand-in for sha1_core: busy from the first beat, digest ready a few cycles after the 16th
    initial begin
        int beats = 0;
        int delay = 0;
        bit nb;
        bit nd;
        core_busy_m   = 1'b0;
        core_dout_vld = 1'b0;
        forever begin
            @(negedge clk);
            nb = core_busy_m;
            nd = 1'b0;
            if (!rst_n) begin
                beats = 0;
                delay = 0;
                nb    = 1'b0;
            end else if (blk_vld) begin
                nb = 1'b1;
                beats++;
                if (beats == 16) begin
                    beats = 0;
                    delay = $urandom_range(1, 5);
                end
            end else if (delay > 0) begin
                delay--;
                if (delay == 0) begin
                    nd = 1'b1;
                    nb = 1'b0;
                end
            end
            @(posedge clk); #1;
            core_busy_m   = nb;
            core_dout_vld = nd;
        end
    end

    // Monitor: pops the scoreboard on every beat and checks burst framing
    initial begin
        int   run = 0;
        logic prev_vld = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n || sb_off) begin
                run = 0;
            end else begin
                if (blk_vld) begin
                    if (!prev_vld) checkOutput("start_while_busy", 64'(core_busy), 64'd0);
                    run++;
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_beat", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("blk_data", 64'(blk_data), 64'(e.data));
                        checkOutput("blk_cont", 64'(blk_cont), 64'(e.cont));
                    end
                end else if (prev_vld) begin
                    checkOutput("burst_len", 64'(run), 64'd16);
                    run = 0;
                end
                if (msg_done) begin
                    done_cnt++;
                    checkOutput("done_pending_beats", 64'(exp_q.size()), 64'd0);
                end
            end
            prev_vld = blk_vld;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bytes_t m;
        bit     ok;
        int     beats;
        int     cyc;
        int     sizes[10] = '{56, 64, 55, 60, 61, 63, 119, 4, 1, 128};

        rst_n     = 1'b0;
        msg_vld   = 1'b0;
        msg_data  = '0;
        msg_last  = 1'b0;
        msg_bytes = '0;
        hold_busy = 1'b0;
`ifdef SHA1_PAD_RAW_EN
        raw_mode  = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_msg_rdy", 64'(msg_rdy), 64'd0);
        checkOutput("reset_blk_vld", 64'(blk_vld), 64'd0);
        checkOutput("reset_blk_data", 64'(blk_data), 64'd0);
        checkOutput("reset_blk_cont", 64'(blk_cont), 64'd0);
        checkOutput("reset_msg_done", 64'(msg_done), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("idle_msg_rdy", 64'(msg_rdy), 64'd1);
        @(posedge clk); #1;

        m = '{8'h61, 8'h62, 8'h63};
        applyStimulus(m, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(rand_msg(sizes[i]), 1'b0, 1'b0);
        end
        applyStimulus(rand_msg(100), 1'b0, 1'b1);
        applyStimulus(rand_msg(8), 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(rand_msg($urandom_range(1, 150)), 1'b0, ($urandom_range(0, 3) == 0));
        end

        // Reset in the middle of a burst
        sb_off = 1'b1;
        driveMessage(rand_msg(20), ok);
        beats = 0;
        cyc   = 0;
        while (beats < 5 && cyc < 500) begin
            @(negedge clk);
            if (blk_vld) beats++;
            cyc++;
        end
        checkOutput("reset_beat_reached", 64'(beats), 64'd5);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_blk_vld", 64'(blk_vld), 64'd0);
        checkOutput("midreset_blk_data", 64'(blk_data), 64'd0);
        checkOutput("midreset_blk_cont", 64'(blk_cont), 64'd0);
        checkOutput("midreset_msg_rdy", 64'(msg_rdy), 64'd0);
        checkOutput("midreset_msg_done", 64'(msg_done), 64'd0);
        @(posedge clk); #1;
        checkOutput("midreset_edge_blk_vld", 64'(blk_vld), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        exp_q.delete();
        sb_off = 1'b0;
        m = '{8'h61, 8'h62, 8'h63};
        applyStimulus(m, 1'b0, 1'b0);

`ifdef SHA1_PAD_RAW_EN
        raw_mode = 1'b1;
        applyStimulus(rand_msg(64), 1'b1, 1'b0);
        driveMessage(rand_msg(8), ok);
        raw_mode = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
        end
        checkOutput("raw_drop_no_done", 64'(done_cnt), 64'(exp_done));
        checkOutput("raw_drop_idle_rdy", 64'(msg_rdy), 64'd1);
        applyStimulus(rand_msg(30), 1'b0, 1'b0);
`endif

        repeat (10) begin
            @(posedge clk); #1;
        end
        checkOutput("final_queue_empty", 64'(exp_q.size()), 64'd0);
        checkOutput("final_done_count", 64'(done_cnt), 64'(exp_done));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
